// File: rtl/cnn_pool_pkg.sv
// Shared constants and helpers for the conv-to-pool row gather blocks.
// Slot positions are computed here so the matcher and the top agree on them.
package cnn_pool_pkg;

    localparam int CONVL2_DATA_W = 224;
    localparam int CONVL2_PERIOD = 26;
    localparam int CONVL1_DATA_W = 112;
    localparam int CONVL1_PERIOD = 28;

    // Ceiling log2, never less than 1 so single-value fields still get a bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int slot_phase(input int first_slot, input int slot_gap, input int k);
        return first_slot + k * slot_gap;
    endfunction

endpackage

// File: rtl/pool_slot_match.sv
// Decodes the phase counter into a capture-slot hit, its row index and a last-row flag.
module pool_slot_match
    import cnn_pool_pkg::*;
#(
    parameter int NUM_ROWS   = 4,
    parameter int FIRST_SLOT = 16,
    parameter int SLOT_GAP   = 3,
    parameter int PHASE_W    = 5,
    parameter int IDX_W      = 2
) (
    input  logic [PHASE_W-1:0] phase,
    output logic               hit,
    output logic [IDX_W-1:0]   idx,
    output logic               last
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_ROWS; k++) begin
            if (phase == PHASE_W'(slot_phase(FIRST_SLOT, SLOT_GAP, k))) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
        last = hit && (idx == IDX_W'(NUM_ROWS - 1));
    end

endmodule

// File: rtl/pool_row_gather.sv
// Gathers NUM_ROWS conv output rows at fixed phase slots and hands the set
// to the pooling stage through a registered valid/ready output.
module pool_row_gather
    import cnn_pool_pkg::*;
#(
    parameter int DATA_W      = CONVL2_DATA_W,
    parameter int NUM_ROWS    = 4,
    parameter int FIRST_SLOT  = 16,
    parameter int SLOT_GAP    = 3,
    parameter int PERIOD      = CONVL2_PERIOD,
    parameter int START_PHASE = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         out_ready,
    input  logic                         clr_overrun,
    output logic                         out_valid,
    output logic [NUM_ROWS*DATA_W-1:0]   out_data,
    output logic [clog2(PERIOD)-1:0]     phase,
    output logic                         overrun
);

    localparam int PHASE_W = clog2(PERIOD);
    localparam int IDX_W   = clog2(NUM_ROWS);

    if (slot_phase(FIRST_SLOT, SLOT_GAP, NUM_ROWS - 1) >= PERIOD) begin : g_bad_slots
        $error("pool_row_gather: last capture slot must lie below PERIOD");
    end
    if (START_PHASE >= PERIOD) begin : g_bad_start
        $error("pool_row_gather: START_PHASE must be below PERIOD");
    end

    logic                       hit;
    logic                       last;
    logic [IDX_W-1:0]           idx;
    logic [NUM_ROWS*DATA_W-1:0] candidate;
    logic                       complete;

    pool_slot_match #(
        .NUM_ROWS   (NUM_ROWS),
        .FIRST_SLOT (FIRST_SLOT),
        .SLOT_GAP   (SLOT_GAP),
        .PHASE_W    (PHASE_W),
        .IDX_W      (IDX_W)
    ) u_match (
        .phase (phase),
        .hit   (hit),
        .idx   (idx),
        .last  (last)
    );

    // The last row never goes through the shadow; it joins the set straight from the input.
    if (NUM_ROWS > 1) begin : g_shadow
        logic [DATA_W-1:0] shadow_q [NUM_ROWS-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < NUM_ROWS - 1; k++) shadow_q[k] <= '0;
            end else if (in_valid && hit && !last) begin
                for (int k = 0; k < NUM_ROWS - 1; k++) begin
                    if (idx == IDX_W'(k)) shadow_q[k] <= in_data;
                end
            end
        end

        for (genvar k = 0; k < NUM_ROWS - 1; k++) begin : g_cand
            assign candidate[k*DATA_W +: DATA_W] = shadow_q[k];
        end
    end
    assign candidate[(NUM_ROWS-1)*DATA_W +: DATA_W] = in_data;

    assign complete = in_valid && last;

    // Handshake: a set transfers on any edge where out_valid and out_ready are both high;
    // out_data is frozen while out_valid is high, and a completion that arrives
    // while the held set is not being taken is dropped and flagged in overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= PHASE_W'(START_PHASE);
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (in_valid) begin
                phase <= (phase == PHASE_W'(PERIOD - 1)) ? '0 : phase + 1'b1;
            end

            if (complete && (!out_valid || out_ready)) begin
                out_data  <= candidate;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (complete && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_row_gather.sv
// Bench for pool_row_gather: default convl2 instance plus a small two-row variant,
// both checked through an expected-set queue drained on each output transfer.
module tb_pool_row_gather;

    localparam int DW = 224;
    localparam int NR = 4;
    localparam int SET_W = NR * DW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    in_data = '0;
    logic             out_ready = 1'b0;
    logic             clr_overrun = 1'b0;
    logic             out_valid;
    logic [SET_W-1:0] out_data;
    logic [4:0]       phase;
    logic             overrun;

    logic             v_rst = 1'b1;
    logic             v_in_valid = 1'b0;
    logic [7:0]       v_in_data = '0;
    logic             v_out_ready = 1'b0;
    logic             v_clr_overrun = 1'b0;
    logic             v_out_valid;
    logic [15:0]      v_out_data;
    logic [1:0]       v_phase;
    logic             v_overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [SET_W-1:0] exp_q[$];
    logic [15:0]      v_exp_q[$];

    int               m_phase;
    logic [DW-1:0]    m_rows [3];
    int               vm_phase;
    logic [7:0]       vm_row0;

    pool_row_gather dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_ready   (out_ready),
        .clr_overrun (clr_overrun),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .phase       (phase),
        .overrun     (overrun)
    );

    pool_row_gather #(
        .DATA_W      (8),
        .NUM_ROWS    (2),
        .FIRST_SLOT  (0),
        .SLOT_GAP    (1),
        .PERIOD      (4),
        .START_PHASE (0)
    ) dut_v (
        .clk         (clk),
        .rst         (v_rst),
        .in_valid    (v_in_valid),
        .in_data     (v_in_data),
        .out_ready   (v_out_ready),
        .clr_overrun (v_clr_overrun),
        .out_valid   (v_out_valid),
        .out_data    (v_out_data),
        .phase       (v_phase),
        .overrun     (v_overrun)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_set(input string tag, input logic [SET_W-1:0] got, input logic [SET_W-1:0] exp);
        for (int k = 0; k < NR; k++) begin
            check($sformatf("%s_row%0d", tag, k), 256'(got[k*DW +: DW]), 256'(exp[k*DW +: DW]));
        end
    endtask

    function automatic logic [SET_W-1:0] mk_set(input int r0, input int r1, input int r2, input int r3);
        return {DW'(r3), DW'(r2), DW'(r1), DW'(r0)};
    endfunction

    // Scoreboard: each transfer pops the oldest expected set
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_set", 256'(1), 256'(0));
            end else begin
                check_set("sb", out_data, exp_q.pop_front());
            end
        end
        if (!v_rst && v_out_valid && v_out_ready) begin
            if (v_exp_q.size() == 0) begin
                check("v_unexpected_set", 256'(1), 256'(0));
            end else begin
                check("v_sb", 256'(v_out_data), 256'(v_exp_q.pop_front()));
            end
        end
    end

    // Driver tasks with the reference gather model
    task automatic model_reset();
        m_phase = 16;
        for (int k = 0; k < 3; k++) m_rows[k] = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        clr_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic beat(input int value);
        logic [DW-1:0] d;
        d = DW'(value);
        in_valid = 1'b1;
        in_data = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (m_phase == 16 + 3 * k) m_rows[k] = d;
        end
        if (m_phase == 25) exp_q.push_back({d, m_rows[2], m_rows[1], m_rows[0]});
        m_phase = (m_phase == 25) ? 0 : m_phase + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic v_beat(input int value);
        logic [7:0] d;
        d = 8'(value);
        v_in_valid = 1'b1;
        v_in_data = d;
        @(posedge clk);
        #1;
        v_in_valid = 1'b0;
        if (vm_phase == 0) vm_row0 = d;
        if (vm_phase == 1) v_exp_q.push_back({d, vm_row0});
        vm_phase = (vm_phase + 1) % 4;
    endtask

    initial begin
        // Test 1: reset state, continuous stream, two sets
        do_reset();
        check("rst_phase", 256'(phase), 256'(16));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_overrun", 256'(overrun), 256'(0));
        check_set("rst_out_data", out_data, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            beat(i);
            if (i == 9) begin
                check("t1_valid_after_b9", 256'(out_valid), 256'(1));
                check_set("t1_set1", out_data, mk_set(0, 3, 6, 9));
                check("t1_phase_wrap", 256'(phase), 256'(0));
            end
            if (i == 10) check("t1_valid_cleared", 256'(out_valid), 256'(0));
            if (i == 35) check_set("t1_set2", out_data, mk_set(26, 29, 32, 35));
        end
        check("t1_phase", 256'(phase), 256'(m_phase));
        idle(2);
        check("t1_drain", 256'(exp_q.size()), 256'(0));

        // Test 2: gaps between beats
        do_reset();
        for (int i = 0; i < 36; i++) begin
            beat(i);
            if (i == 3) begin
                check("t2_phase_b3", 256'(phase), 256'(20));
                idle(5);
                check("t2_phase_frozen", 256'(phase), 256'(20));
            end else begin
                idle(5);
            end
        end
        check("t2_drain", 256'(exp_q.size()), 256'(0));

        // Test 3: no ready, drop and overrun, set-over-clear priority
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 35; i++) beat(i);
        check("t3_held_valid", 256'(out_valid), 256'(1));
        check("t3_no_overrun_yet", 256'(overrun), 256'(0));
        clr_overrun = 1'b1;
        beat(35);
        clr_overrun = 1'b0;
        check("t3_overrun_set", 256'(overrun), 256'(1));
        check_set("t3_held_set", out_data, mk_set(0, 3, 6, 9));
        clr_overrun = 1'b1;
        idle(1);
        clr_overrun = 1'b0;
        check("t3_overrun_cleared", 256'(overrun), 256'(0));

        // Test 4: ready only on the completing edge
        do_reset();
        for (int i = 0; i < 35; i++) beat(i);
        out_ready = 1'b1;
        beat(35);
        out_ready = 1'b0;
        check("t4_valid_kept", 256'(out_valid), 256'(1));
        check("t4_no_overrun", 256'(overrun), 256'(0));
        check_set("t4_set2", out_data, mk_set(26, 29, 32, 35));
        out_ready = 1'b1;
        idle(1);
        check("t4_valid_dropped", 256'(out_valid), 256'(0));
        check_set("t4_data_retained", out_data, mk_set(26, 29, 32, 35));
        check("t4_drain", 256'(exp_q.size()), 256'(0));

        // Test 5: reset in the middle of a set
        do_reset();
        for (int i = 0; i < 6; i++) beat(50 + i);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        model_reset();
        check("t5_phase", 256'(phase), 256'(16));
        check("t5_out_valid", 256'(out_valid), 256'(0));
        for (int i = 0; i < 10; i++) beat(100 + i);
        check_set("t5_set", out_data, mk_set(100, 103, 106, 109));
        idle(2);
        check("t5_drain", 256'(exp_q.size()), 256'(0));

        // Test 6: two-row variant
        vm_phase = 0;
        vm_row0 = '0;
        repeat (2) @(posedge clk);
        #1;
        v_rst = 1'b0;
        check("t6_rst_valid", 256'(v_out_valid), 256'(0));
        check("t6_rst_phase", 256'(v_phase), 256'(0));
        v_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v_beat(8'hA0 + i);
            if (i == 1) check("t6_set1", 256'(v_out_data), 256'(16'hA1A0));
            if (i == 9) check("t6_set3", 256'(v_out_data), 256'(16'hA9A8));
        end
        idle(2);
        check("t6_drain", 256'(v_exp_q.size()), 256'(0));
        check("t6_overrun", 256'(v_overrun), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
